// File: rtl/sampler_pkg.sv
// Shared types and default widths for the sampler note playback engine.
package sampler_pkg;

  localparam int DEFAULT_ADDR_W = 20;
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_LEN_W  = 16;
  localparam int DEFAULT_FRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0]               base;
    logic [DEFAULT_LEN_W-1:0]                len;
    logic [DEFAULT_LEN_W+DEFAULT_FRAC_W-1:0] step;
  } note_desc_t;

endpackage

// File: rtl/note_sample_engine_phase_accumulator.sv
// Fixed-point phase accumulator: holds base and step of the current note and
// presents the sample address the next advance would fetch.
module phase_accumulator #(
  parameter int ADDR_W = 20,
  parameter int LEN_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [ADDR_W-1:0]       base_i,
  input  logic [LEN_W+FRAC_W-1:0] step_i,
  input  logic                    advance_i,
  output logic [ADDR_W-1:0]       next_addr_o
);

  localparam int PH_W = LEN_W + FRAC_W;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [PH_W-1:0]   step_q, step_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [PH_W-1:0]   phase_sum;
  logic [LEN_W-1:0]  int_part;

  // Sum wraps modulo 2^PH_W; only the integer part steers the address.
  assign phase_sum   = phase_q + step_q;
  assign int_part    = phase_sum[PH_W-1:FRAC_W];
  assign next_addr_o = base_q + ADDR_W'(int_part);

  always_comb begin
    base_d  = base_q;
    step_d  = step_q;
    phase_d = phase_q;
    if (load_i) begin
      base_d  = base_i;
      step_d  = step_i;
      phase_d = '0;
    end else if (advance_i) begin
      phase_d = phase_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      step_q  <= '0;
      phase_q <= '0;
    end else begin
      base_q  <= base_d;
      step_q  <= step_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/note_sample_engine.sv
// Note playback datapath: preloads and fetches samples over req/ack, counts
// played samples and publishes the buffered sample on each Done pulse.
module note_sample_engine
  import sampler_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LEN_W  = DEFAULT_LEN_W,
  parameter int FRAC_W = DEFAULT_FRAC_W
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    note_start,
  input  logic [ADDR_W-1:0]       note_base,
  input  logic [LEN_W-1:0]        note_len,
  input  logic [LEN_W+FRAC_W-1:0] note_step,
  input  logic                    note_stop,
  input  logic                    increment,
  input  logic                    count_inc,
  input  logic                    Done,
  output logic                    new_note,
  output logic                    count_done,
  output logic                    mem_rd_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_rd_ack,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic [DATA_W-1:0]       sample_out,
  output logic                    sample_valid,
  output logic                    underrun
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] fbuf_q, fbuf_d;
  logic              fbuf_valid_q, fbuf_valid_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              underrun_q, underrun_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              done_seen_q, done_seen_d;

  logic              active;
  logic              start_ok;
  logic              advance;
  logic              outstanding;
  logic              note_end;
  logic [ADDR_W-1:0] acc_addr;

  assign active      = (state_q == PLAY) || (state_q == FETCH);
  assign start_ok    = (state_q == IDLE) && note_start && !note_stop && (note_len != '0);
  assign advance     = active && increment;
  // An ack in this cycle completes the fetch, so nothing is left to drain.
  assign outstanding = req_q && !mem_rd_ack;
  assign note_end    = active && done_seen_q && count_done;

  phase_accumulator #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W),
    .FRAC_W(FRAC_W)
  ) u_phase (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .load_i     (start_ok),
    .base_i     (note_base),
    .step_i     (note_step),
    .advance_i  (advance),
    .next_addr_o(acc_addr)
  );

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    count_d        = count_q;
    fbuf_d         = fbuf_q;
    fbuf_valid_d   = fbuf_valid_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    underrun_d     = underrun_q;
    req_d          = req_q;
    addr_d         = addr_q;
    pend_valid_d   = pend_valid_q;
    pend_addr_d    = pend_addr_q;
    done_seen_d    = active && Done;

    if (active && count_inc && (count_q != len_q)) begin
      count_d = count_q + LEN_W'(1);
    end

    // Done consumes the buffer before a same-cycle ack refills it below.
    if (active && Done) begin
      sample_valid_d = 1'b1;
      if (fbuf_valid_q) begin
        sample_d     = fbuf_q;
        fbuf_valid_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          len_d        = note_len;
          count_d      = '0;
          underrun_d   = 1'b0;
          fbuf_valid_d = 1'b0;
          pend_valid_d = 1'b0;
          addr_d       = note_base;
          req_d        = 1'b1;
          state_d      = FETCH;
        end
      end
      PLAY: begin
        if (advance) begin
          addr_d  = acc_addr;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (mem_rd_ack) begin
          fbuf_d       = mem_rdata;
          fbuf_valid_d = 1'b1;
          pend_valid_d = 1'b0;
          if (advance) begin
            addr_d = acc_addr;
          end else if (pend_valid_q) begin
            addr_d = pend_addr_q;
          end else begin
            req_d   = 1'b0;
            state_d = PLAY;
          end
        end else if (advance) begin
          pend_addr_d  = acc_addr;
          pend_valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (mem_rd_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (active && (note_stop || note_end)) begin
      pend_valid_d = 1'b0;
      addr_d       = addr_q;
      req_d        = outstanding;
      state_d      = outstanding ? DRAIN : IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= IDLE;
      len_q          <= '0;
      count_q        <= '0;
      fbuf_q         <= '0;
      fbuf_valid_q   <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      req_q          <= 1'b0;
      addr_q         <= '0;
      pend_valid_q   <= 1'b0;
      pend_addr_q    <= '0;
      done_seen_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      count_q        <= count_d;
      fbuf_q         <= fbuf_d;
      fbuf_valid_q   <= fbuf_valid_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
      req_q          <= req_d;
      addr_q         <= addr_d;
      pend_valid_q   <= pend_valid_d;
      pend_addr_q    <= pend_addr_d;
      done_seen_q    <= done_seen_d;
    end
  end

  assign new_note     = active;
  assign count_done   = (state_q != IDLE) && (count_q == len_q);
  assign mem_rd_req   = req_q;
  assign mem_addr     = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_note_sample_engine.sv
// Directed bench for note_sample_engine with a latency-programmable memory responder.
module tb_note_sample_engine;
  import sampler_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        note_start, note_stop, increment, count_inc, Done;
  logic [19:0] note_base;
  logic [15:0] note_len;
  logic [23:0] note_step;
  logic        new_note, count_done, mem_rd_req, mem_rd_ack, sample_valid, underrun;
  logic [19:0] mem_addr;
  logic [15:0] mem_rdata, sample_out;

  int          checks = 0;
  int          errors = 0;
  int          ack_lat = 0;
  int          wait_cnt = 0;
  logic [19:0] addr_log[$];
  logic [15:0] pub_q[$];

  note_sample_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .note_start(note_start), .note_base(note_base),
    .note_len(note_len), .note_step(note_step), .note_stop(note_stop),
    .increment(increment), .count_inc(count_inc), .Done(Done), .new_note(new_note),
    .count_done(count_done), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata), .sample_out(sample_out),
    .sample_valid(sample_valid), .underrun(underrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] mem_fn(input logic [19:0] a);
    if (a == 20'h00300) return 16'h7FFF;
    if (a == 20'h00301) return 16'h8000;
    return 16'h5A00 ^ a[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_note(input note_desc_t d);
    note_base  = d.base;
    note_len   = d.len;
    note_step  = d.step;
    note_start = 1'b1;
    tick();
    note_start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input state_e s, input int max);
    int n = 0;
    while (dut.state_q != s && n < max) begin
      tick();
      n++;
    end
    check(tag, 32'(dut.state_q), 32'(s));
  endtask

  // Per sample: count_inc, then increment together with Done; returns one
  // cycle after the final increment/Done pair is sampled.
  task automatic run_note(input note_desc_t d);
    start_note(d);
    tick();
    tick();
    for (int i = 0; i < int'(d.len); i++) begin
      count_inc = 1'b1;
      tick();
      count_inc = 1'b0;
      increment = 1'b1;
      Done      = 1'b1;
      tick();
      increment = 1'b0;
      Done      = 1'b0;
      if (i < int'(d.len) - 1) begin
        tick();
        tick();
      end
    end
  endtask

  // Memory responder: acks ack_lat cycles after the request is first seen.
  initial begin
    mem_rd_ack = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge Clk);
      #1;
      mem_rd_ack = 1'b0;
      if (mem_rd_req) begin
        if (wait_cnt >= ack_lat) begin
          mem_rd_ack = 1'b1;
          mem_rdata  = mem_fn(mem_addr);
          addr_log.push_back(mem_addr);
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      if (sample_valid) pub_q.push_back(sample_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    note_start = 1'b0; note_stop = 1'b0; increment = 1'b0; count_inc = 1'b0; Done = 1'b0;
    note_base = '0; note_len = '0; note_step = '0;

    // Reset state
    #12;
    check("rst_new_note", 32'(new_note), 32'h0);
    check("rst_count_done", 32'(count_done), 32'h0);
    check("rst_req", 32'(mem_rd_req), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_sample_out", 32'(sample_out), 32'h0);
    check("rst_sample_valid", 32'(sample_valid), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    #1 Reset_n = 1'b1;
    tick();

    // Step 1.0 from 0x100, four samples
    ack_lat = 0;
    addr_log.delete();
    pub_q.delete();
    run_note('{base: 20'h00100, len: 16'd4, step: 24'h000100});
    check("t1_count_done", 32'(count_done), 32'h1);
    check("t1_new_note_hi", 32'(new_note), 32'h1);
    tick();
    check("t1_new_note_lo", 32'(new_note), 32'h0);
    check("t1_count_done_lo", 32'(count_done), 32'h0);
    tick();
    tick();
    check("t1_fetch_cnt", 32'(addr_log.size()), 32'd5);
    if (addr_log.size() == 5) begin
      check("t1_addr0", 32'(addr_log[0]), 32'h100);
      check("t1_addr2", 32'(addr_log[2]), 32'h102);
      check("t1_addr4", 32'(addr_log[4]), 32'h104);
    end
    check("t1_valid_cnt", 32'(pub_q.size()), 32'd4);
    if (pub_q.size() == 4) begin
      check("t1_pub0", 32'(pub_q[0]), 32'h5B00);
      check("t1_pub3", 32'(pub_q[3]), 32'h5B03);
    end
    check("t1_underrun", 32'(underrun), 32'h0);

    // Step 1.5 from 0x10
    addr_log.delete();
    run_note('{base: 20'h00010, len: 16'd4, step: 24'h000180});
    tick();
    tick();
    tick();
    check("t2_fetch_cnt", 32'(addr_log.size()), 32'd5);
    if (addr_log.size() == 5) begin
      check("t2_addr1", 32'(addr_log[1]), 32'h11);
      check("t2_addr2", 32'(addr_log[2]), 32'h13);
      check("t2_addr3", 32'(addr_log[3]), 32'h14);
      check("t2_addr4", 32'(addr_log[4]), 32'h16);
    end

    // Underrun: Done while a slow fetch is outstanding
    start_note('{base: 20'h00200, len: 16'd4, step: 24'h000100});
    tick();
    tick();
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("t3_pub_preload", 32'(sample_out), 32'h5800);
    ack_lat   = 10;
    increment = 1'b1;
    tick();
    increment = 1'b0;
    tick();
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check("t3_valid", 32'(sample_valid), 32'h1);
    check("t3_held", 32'(sample_out), 32'h5800);
    check("t3_underrun", 32'(underrun), 32'h1);
    wait_state("t3_back_play", PLAY, 20);
    note_stop = 1'b1;
    tick();
    note_stop = 1'b0;
    check("t3_idle", 32'(dut.state_q), 32'(IDLE));
    check("t3_sticky", 32'(underrun), 32'h1);

    // Stop during fetch: drain with start ignored
    ack_lat = 5;
    pub_q.delete();
    start_note('{base: 20'h00250, len: 16'd4, step: 24'h000100});
    check("t4_underrun_clr", 32'(underrun), 32'h0);
    check("t4_req", 32'(mem_rd_req), 32'h1);
    note_stop = 1'b1;
    tick();
    note_stop = 1'b0;
    check("t4_drain", 32'(dut.state_q), 32'(DRAIN));
    check("t4_new_note", 32'(new_note), 32'h0);
    check("t4_req_held", 32'(mem_rd_req), 32'h1);
    start_note('{base: 20'h00400, len: 16'd2, step: 24'h000100});
    check("t4_start_ign", 32'(dut.state_q), 32'(DRAIN));
    check("t4_addr_stable", 32'(mem_addr), 32'h250);
    wait_state("t4_idle", IDLE, 20);
    check("t4_req_lo", 32'(mem_rd_req), 32'h0);
    check("t4_sample_kept", 32'(sample_out), 32'h5800);
    check("t4_no_pub", 32'(pub_q.size()), 32'd0);
    check("t4_discard", 32'(dut.fbuf_valid_q), 32'h0);

    // Zero-length note ignored
    start_note('{base: 20'h00500, len: 16'd0, step: 24'h000100});
    tick();
    check("t5_len0_note", 32'(new_note), 32'h0);
    check("t5_len0_req", 32'(mem_rd_req), 32'h0);

    // Asynchronous reset in the middle of a fetch
    ack_lat = 10;
    start_note('{base: 20'h00040, len: 16'd4, step: 24'h000100});
    tick();
    check("t5_pre_req", 32'(mem_rd_req), 32'h1);
    #3 Reset_n = 1'b0;
    #1;
    check("t5_rst_req", 32'(mem_rd_req), 32'h0);
    check("t5_rst_addr", 32'(mem_addr), 32'h0);
    check("t5_rst_note", 32'(new_note), 32'h0);
    check("t5_rst_sample", 32'(sample_out), 32'h0);
    check("t5_rst_state", 32'(dut.state_q), 32'(IDLE));
    #2 Reset_n = 1'b1;
    tick();

    // increment + count_inc + Done together with a same-cycle ack
    ack_lat = 0;
    start_note('{base: 20'h00300, len: 16'd2, step: 24'h000100});
    tick();
    tick();
    increment = 1'b1;
    tick();
    increment = 1'b0;
    check("t6_req_301", 32'(mem_addr), 32'h301);
    increment = 1'b1;
    count_inc = 1'b1;
    Done      = 1'b1;
    tick();
    increment = 1'b0;
    count_inc = 1'b0;
    Done      = 1'b0;
    check("t6_sample", 32'(sample_out), 32'h7FFF);
    check("t6_valid", 32'(sample_valid), 32'h1);
    check("t6_fbuf", 32'(dut.fbuf_q), 32'h8000);
    check("t6_fbuf_valid", 32'(dut.fbuf_valid_q), 32'h1);
    check("t6_count", 32'(dut.count_q), 32'd1);
    check("t6_next_addr", 32'(mem_addr), 32'h302);
    for (int i = 0; i < 3; i++) begin
      count_inc = 1'b1;
      tick();
      count_inc = 1'b0;
    end
    check("t6_count_sat", 32'(dut.count_q), 32'd2);
    check("t6_count_done", 32'(count_done), 32'h1);
    note_stop = 1'b1;
    tick();
    note_stop = 1'b0;
    wait_state("t6_idle", IDLE, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sample_engine.md
Name: note_sample_engine

Overview:
- Datapath and responder for the sampler's playback increment controller.
- Accepts a note descriptor (base address, length in samples, pitch step) and raises new_note to start the controller's per-sample loop.
- Responds to each increment pulse by advancing a fixed-point phase accumulator and fetching one sample from sample memory over a req/ack handshake.
- Responds to count_inc by counting played samples and raising count_done at note length. On each Done pulse it presents the latest fetched sample to the audio output path.

Parameters:
ADDR_W, 20, sample memory word-address width
DATA_W, 16, sample width (signed PCM)
LEN_W, 16, note length counter width
FRAC_W, 8, fractional bits of phase step/accumulator

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
note_start  in  1  one-cycle pulse: latch note descriptor
note_base  in  ADDR_W  first sample address of note
note_len  in  LEN_W  samples to play (0 = ignore start)
note_step  in  LEN_W+FRAC_W  phase increment per sample, unsigned fixed point
note_stop  in  1  one-cycle pulse: abort current note
increment  in  1  controller pulse: advance phase, fetch next sample
count_inc  in  1  controller pulse: one sample consumed
Done  in  1  controller pulse: sample period complete, publish sample
new_note  out  1  note armed/playing, not yet complete
count_done  out  1  played count reached note_len
mem_rd_req  out  1  read request, held until ack
mem_addr  out  ADDR_W  read address, stable while req high
mem_rd_ack  in  1  one-cycle read acknowledge, data valid same cycle
mem_rdata  in  DATA_W  read data
sample_out  out  DATA_W  current output sample
sample_valid  out  1  one-cycle pulse when sample_out updates
underrun  out  1  sticky: Done arrived with fetch outstanding; cleared by note_start

Behaviour:
- Reset (async, Reset_n low): state IDLE. All outputs 0. Phase, count and descriptor registers cleared. Reset mid-fetch abandons the request immediately.
- FSM states: IDLE, PLAY, FETCH, DRAIN.
- IDLE:
  - note_start with note_len!=0 latches base/len/step, clears phase, count and underrun, then goes to PLAY. new_note rises the following cycle.
  - note_len==0 is ignored.
  - increment, count_inc and Done are ignored.
- PLAY:
  - increment: phase <= phase + step (width LEN_W+FRAC_W, wraps modulo 2^(LEN_W+FRAC_W)). mem_addr <= base + phase_new[integer part] (mod 2^ADDR_W). mem_rd_req high next cycle. Go to FETCH.
  - The first increment of a note fetches base + step integer part; the sample at base itself is the preload issued on entry to PLAY.
  - Entry to PLAY from IDLE issues one preload fetch at base, passing through FETCH.
- FETCH:
  - mem_rd_req held high and mem_addr stable until mem_rd_ack.
  - On ack, mem_rdata goes to the fetch buffer (fbuf_valid=1) and the FSM returns to PLAY.
  - increment during FETCH: phase still advances and the new address is latched into a pending slot. The pending fetch is reissued the cycle after ack, so at most one is pending and a later increment overwrites it.
- count_inc (PLAY or FETCH): count <= count+1, saturating at note_len.
- count_done: combinational (count == len) from registers while state != IDLE. Valid the cycle after count_inc, so it is stable before the controller samples it two cycles later.
- Done:
  - If fbuf_valid: sample_out <= fbuf, sample_valid pulses 1 cycle, fbuf_valid <= 0.
  - Else sample_out is held, sample_valid still pulses, and underrun is set.
- Note end: on the cycle after Done while count_done=1:
  - If no fetch is outstanding, go to IDLE; new_note and count_done drop next cycle.
  - If a fetch is outstanding, go to DRAIN.
- note_stop in PLAY/FETCH: go to DRAIN if req outstanding, else IDLE. new_note drops next cycle.
- DRAIN: hold req until ack, discard data, then go to IDLE. note_start in DRAIN is ignored.
- Simultaneous increment+count_inc+Done in one cycle: all three are processed; Done publishes the buffer contents before this cycle's ack is captured.
- Simultaneous note_stop and note_start: stop wins.

Decomposition:
- Package sampler_pkg: state enum (2-bit), width localparams (DEFAULT_ADDR_W, DEFAULT_DATA_W), and a note descriptor struct (base, len, step).
- One sub-module, phase_accumulator: step register, accumulator, integer-part extract, and base-address add.
- The FSM, counter and fetch buffer stay in the top module.

Test Plan:
- Reset with note_len=4, step=1.0 (0x100), base=0x100 -> fetches at 0x100,0x101,0x102,0x103,0x104 in order. sample_valid pulses exactly 4 times. count_done high after 4th count_inc. new_note low two cycles after final Done.
- step=0x180 (1.5), base=0x10, 4 increments -> mem_addr sequence 0x10,0x11,0x13,0x14,0x16.
- mem_rd_ack delayed 10 cycles, Done at cycle 3 after increment -> sample_out unchanged, sample_valid pulses, underrun=1. Next note_start clears underrun.
- note_stop while mem_rd_req high and ack 5 cycles later -> FSM in DRAIN, req held until ack, new_note low, sample_out not updated, then IDLE. note_start during DRAIN has no effect.
- note_start with note_len=0 -> no new_note, no mem_rd_req. Reset_n pulsed low mid-FETCH -> all outputs 0 asynchronously, req dropped.
- increment, count_inc and Done asserted in the same cycle with fbuf holding 0x7FFF and ack returning 0x8000 -> sample_out=0x7FFF, fbuf then holds 0x8000, count increments by 1.
